// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared control constants for the multi-cycle RISC-V sequencer.
// Holds the sequencer state encoding, opcode/funct3 values, ALU operations
// and immediate format selects used by the sequencer and its classifier.
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WB,
        S_BRANCH,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_IMM    = 7'd19;
    localparam logic [6:0] OP_BRANCH = 7'd99;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_BNE  = 3'b001;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    localparam logic IMM_I = 1'b0;
    localparam logic IMM_B = 1'b1;

    // Canonical NOP (addi x0,x0,0) loaded into the IR on reset.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/rv_instr_classify.sv
// rv_instr_classify: combinational instruction classifier.
// Maps the opcode and funct3 fields of the IR onto the supported
// instruction set (addi, lw, bne); everything else is flagged illegal.
module rv_instr_classify
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output logic       is_addi,
    output logic       is_lw,
    output logic       is_bne,
    output logic       illegal
);

    // Exactly one of the four flags is high for any encoding.
    always_comb begin
        is_addi = (opcode == OP_IMM)    && (funct3 == F3_ADDI);
        is_lw   = (opcode == OP_LOAD)   && (funct3 == F3_LW);
        is_bne  = (opcode == OP_BRANCH) && (funct3 == F3_BNE);
        illegal = !(is_addi || is_lw || is_bne);
    end

endmodule

// File: rtl/rv_multicycle_sequencer.sv
// rv_multicycle_sequencer: multi-cycle control FSM for the reduced RISC-V core.
// Steps addi/lw/bne through FETCH, DECODE, EXECUTE, MEM, WB and BRANCH and
// drives the datapath enables with registered Moore outputs. pc_src in BRANCH
// follows the ALU eq flag combinationally. Illegal encodings lock into TRAP.
// Optional feature macro: INSTRET_EN adds a 32-bit retired-instruction counter
// output 'instret'.
module rv_multicycle_sequencer
    import rv_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    input  logic                  imem_ready,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  dmem_req,
    input  logic                  dmem_ready,
    input  logic                  eq,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  imm_sel,
    output logic [2:0]            alu_ctrl,
    output logic                  alu_src,
    output logic                  reg_write,
    output logic                  pc_en,
    output logic                  pc_src,
    output logic                  trap
`ifdef INSTRET_EN
    ,
    output logic [31:0]           instret
`endif
);

    localparam logic [DATA_WIDTH-1:0] IR_RESET = DATA_WIDTH'(NOP_INSTR);

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] ir_nxt;
    logic                  in_branch;

    logic                  is_addi;
    logic                  is_lw;
    logic                  is_bne;
    logic                  illegal;

    logic                  imem_req_nxt;
    logic                  dmem_req_nxt;
    logic                  imm_sel_nxt;
    logic [2:0]            alu_ctrl_nxt;
    logic                  alu_src_nxt;
    logic                  reg_write_nxt;
    logic                  pc_en_nxt;
    logic                  in_branch_nxt;
    logic                  trap_nxt;

    rv_instr_classify u_classify (
        .opcode  (instr[6:0]),
        .funct3  (instr[14:12]),
        .is_addi (is_addi),
        .is_lw   (is_lw),
        .is_bne  (is_bne),
        .illegal (illegal)
    );

    // Next state and IR; the IR only takes new data on the FETCH->DECODE step.
    always_comb begin
        state_nxt = state;
        ir_nxt    = instr;
        case (state)
            S_IDLE:    state_nxt = S_FETCH;
            S_FETCH: begin
                if (imem_ready) begin
                    ir_nxt    = imem_rdata;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (illegal)     state_nxt = S_TRAP;
                else if (is_bne) state_nxt = S_BRANCH;
                else             state_nxt = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (is_lw)        state_nxt = S_MEM;
                else if (is_addi) state_nxt = S_WB;
                else              state_nxt = S_TRAP;
            end
            S_MEM:     if (dmem_ready) state_nxt = S_WB;
            S_WB:      state_nxt = S_FETCH;
            S_BRANCH:  state_nxt = S_FETCH;
            S_TRAP:    state_nxt = S_TRAP;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Output values for the state being entered, so outputs come straight from flops.
    always_comb begin
        imem_req_nxt  = (state_nxt == S_FETCH);
        dmem_req_nxt  = (state_nxt == S_MEM);
        alu_src_nxt   = (state_nxt == S_EXECUTE) || (state_nxt == S_MEM) || (state_nxt == S_WB);
        in_branch_nxt = (state_nxt == S_BRANCH);
        imm_sel_nxt   = in_branch_nxt ? IMM_B : IMM_I;
        alu_ctrl_nxt  = in_branch_nxt ? ALU_SUB : ALU_ADD;
        reg_write_nxt = (state_nxt == S_WB);
        pc_en_nxt     = (state_nxt == S_WB) || in_branch_nxt;
        trap_nxt      = (state_nxt == S_TRAP);
    end

    // State, IR and registered control outputs; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            instr     <= IR_RESET;
            imem_req  <= 1'b0;
            dmem_req  <= 1'b0;
            imm_sel   <= IMM_I;
            alu_ctrl  <= ALU_ADD;
            alu_src   <= 1'b0;
            reg_write <= 1'b0;
            pc_en     <= 1'b0;
            in_branch <= 1'b0;
            trap      <= 1'b0;
        end else begin
            state     <= state_nxt;
            instr     <= ir_nxt;
            imem_req  <= imem_req_nxt;
            dmem_req  <= dmem_req_nxt;
            imm_sel   <= imm_sel_nxt;
            alu_ctrl  <= alu_ctrl_nxt;
            alu_src   <= alu_src_nxt;
            reg_write <= reg_write_nxt;
            pc_en     <= pc_en_nxt;
            in_branch <= in_branch_nxt;
            trap      <= trap_nxt;
        end
    end

    // Branch target is taken when the operands differ; WB always falls through.
    always_comb begin
        pc_src = in_branch && !eq;
    end

`ifdef INSTRET_EN
    // Retired-instruction counter, one count per pc_en strobe, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            instret <= 32'd0;
        end else if (pc_en) begin
            instret <= instret + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rv_multicycle_sequencer.sv
// tb_rv_multicycle_sequencer: self-checking bench for rv_multicycle_sequencer.
// Expected outputs are derived per instruction from its class and the ready
// wait counts (phase windows computed arithmetically), then compared cycle by
// cycle. Directed cases come first, followed by randomized instruction streams.
module tb_rv_multicycle_sequencer;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_ready;
    logic        eq;
    logic [31:0] instr;
    logic        imm_sel;
    logic [2:0]  alu_ctrl;
    logic        alu_src;
    logic        reg_write;
    logic        pc_en;
    logic        pc_src;
    logic        trap;
`ifdef INSTRET_EN
    logic [31:0] instret;
`endif

    int          checks;
    int          failures;
    logic [31:0] ir_model;
    int unsigned retired;

    rv_multicycle_sequencer #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_ready (dmem_ready),
        .eq         (eq),
        .instr      (instr),
        .imm_sel    (imm_sel),
        .alu_ctrl   (alu_ctrl),
        .alu_src    (alu_src),
        .reg_write  (reg_write),
        .pc_en      (pc_en),
        .pc_src     (pc_src),
        .trap       (trap)
`ifdef INSTRET_EN
        ,
        .instret    (instret)
`endif
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // 0 = addi, 1 = lw, 2 = bne, 3 = illegal
    function automatic int classifyWord(input logic [31:0] w);
        if (w[6:0] == 7'd19 && w[14:12] == 3'b000) return 0;
        if (w[6:0] == 7'd3  && w[14:12] == 3'b010) return 1;
        if (w[6:0] == 7'd99 && w[14:12] == 3'b001) return 2;
        return 3;
    endfunction

    task automatic checkInstret();
`ifdef INSTRET_EN
        checkOutput("instret", instret, retired);
`endif
    endtask

    // Hold reset for n edges checking the quiet state, then release into FETCH.
    task automatic applyReset(input int n);
        rst        = 1'b1;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        imem_rdata = $urandom;
        repeat (n) begin
            @(posedge clk);
            #1;
            checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
            checkOutput("rst_dmem_req", 32'(dmem_req), 32'd0);
            checkOutput("rst_pc_en", 32'(pc_en), 32'd0);
            checkOutput("rst_reg_write", 32'(reg_write), 32'd0);
            checkOutput("rst_pc_src", 32'(pc_src), 32'd0);
            checkOutput("rst_alu_src", 32'(alu_src), 32'd0);
            checkOutput("rst_imm_sel", 32'(imm_sel), 32'd0);
            checkOutput("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
            checkOutput("rst_trap", 32'(trap), 32'd0);
            checkOutput("rst_instr", instr, 32'h0000_0013);
            retired = 0;
            checkInstret();
        end
        rst      = 1'b0;
        ir_model = 32'h0000_0013;
        #1;
        checkOutput("idle_imem_req", 32'(imem_req), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("first_imem_req", 32'(imem_req), 32'd1);
    endtask

    // Run one instruction from FETCH entry; abortK >= 0 raises rst in that cycle.
    task automatic applyStimulus(input logic [31:0] word, input int iwait, input int dwait,
                                 input logic eqv, input int abortK);
        int kind;
        int dec;
        int retire;
        int last;
        int memLo;
        int memHi;
        logic atRetire;
        kind   = classifyWord(word);
        dec    = iwait + 1;
        memLo  = dec + 2;
        memHi  = dec + 2 + dwait;
        retire = (kind == 0) ? dec + 2 : (kind == 1) ? dec + 3 + dwait : (kind == 2) ? dec + 1 : -1;
        last   = (kind == 3) ? dec + 4 : retire;
        for (int k = 0; k <= last; k++) begin
            imem_ready = (k == iwait) ? 1'b1 : ((k > iwait) ? 1'($urandom) : 1'b0);
            imem_rdata = (k == iwait) ? word : $urandom;
            if (kind == 1 && k >= memLo && k <= memHi) dmem_ready = (k == memHi);
            else                                       dmem_ready = 1'($urandom);
            eq = eqv;
            #1;
            atRetire = (k == retire);
            checkOutput("imem_req", 32'(imem_req), 32'(k <= iwait));
            checkOutput("dmem_req", 32'(dmem_req), 32'(kind == 1 && k >= memLo && k <= memHi));
            checkOutput("pc_en", 32'(pc_en), 32'(atRetire));
            checkOutput("reg_write", 32'(reg_write), 32'(atRetire && kind != 2));
            checkOutput("pc_src", 32'(pc_src), 32'(atRetire && kind == 2 && !eqv));
            checkOutput("alu_src", 32'(alu_src), 32'(kind < 2 && k > dec && k <= retire));
            checkOutput("imm_sel", 32'(imm_sel), 32'(atRetire && kind == 2));
            checkOutput("alu_ctrl", 32'(alu_ctrl), (atRetire && kind == 2) ? 32'd1 : 32'd0);
            checkOutput("trap", 32'(trap), 32'(kind == 3 && k > dec));
            checkOutput("instr", instr, (k <= iwait) ? ir_model : word);
            checkInstret();
            if (k == abortK) begin
                rst = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
        ir_model = word;
        if (retire >= 0) retired++;
    endtask

    initial begin
        logic [31:0] w;
        checks     = 0;
        failures   = 0;
        retired    = 0;
        ir_model   = 32'h0000_0013;
        rst        = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = 32'd0;
        dmem_ready = 1'b0;
        eq         = 1'b0;

        applyReset(3);

        // Directed: addi, lw with delayed data, bne taken and not taken.
        applyStimulus(32'h0050_0093, 0, 0, 1'b0, -1);
        applyStimulus(32'h0000_A103, 0, 2, 1'b1, -1);
        applyStimulus(32'hFE20_9EE3, 0, 0, 1'b0, -1);
        applyStimulus(32'hFE20_9EE3, 1, 0, 1'b1, -1);
        applyStimulus(32'h0050_0093, 2, 0, 1'b1, -1);

        // Directed: R-type traps and sticks until reset.
        applyStimulus(32'h0000_0033, 0, 0, 1'b0, -1);
        applyReset(2);

        // Directed: reset in the middle of a MEM wait and of a FETCH wait.
        applyStimulus(32'h0000_A103, 0, 0, 1'b0, -1);
        applyStimulus(32'h0040_A183, 0, 6, 1'b0, 4);
        applyReset(1);
        applyStimulus(32'h0050_0093, 3, 0, 1'b0, 1);
        applyReset(1);

        // Randomized instruction stream; illegal words end in a reset.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: w = {12'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'd19};
                1: w = {12'($urandom), 5'($urandom), 3'b010, 5'($urandom), 7'd3};
                2: w = {7'($urandom), 5'($urandom), 5'($urandom), 3'b001, 5'($urandom), 7'd99};
                default: w = $urandom;
            endcase
            applyStimulus(w, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), -1);
            if (classifyWord(w) == 3) applyReset($urandom_range(1, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv_multicycle_sequencer.md
# rv_multicycle_sequencer

Multi-cycle control sequencer for the reduced RISC-V core: steps each instruction through fetch, decode, execute, memory and writeback, and drives the register file, ALU, PC and memory enables one phase at a time. Replaces single-cycle combinational control and sits between the instruction/data memory handshakes and the existing datapath (PC register, register file, sign extender, ALU). Supported instructions: `addi`, `lw` and `bne`. Any other encoding traps.

## Interface
- `DATA_WIDTH`, default 32: instruction and data width.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: instruction fetch request.
- `imem_ready` in 1: instruction data valid this cycle.
- `imem_rdata` in DATA_WIDTH: fetched instruction.
- `dmem_req` out 1: data read request (lw).
- `dmem_ready` in 1: load data valid this cycle.
- `eq` in 1: ALU zero/equal flag.
- `instr` out DATA_WIDTH: instruction register (IR) contents, used by the register-file address and immediate logic.
- `imm_sel` out 1: immediate format; 0 = I-type, 1 = B-type.
- `alu_ctrl` out 3: ALU operation; 3'b000 ADD, 3'b001 SUB.
- `alu_src` out 1: 1 = immediate, 0 = rs2.
- `reg_write` out 1: register file write enable.
- `pc_en` out 1: PC update strobe.
- `pc_src` out 1: 1 = PC+imm, 0 = PC+4; only meaningful with `pc_en`.
- `trap` out 1: illegal instruction detected; sticky.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WB, BRANCH, TRAP.
- Outputs are decoded from the state and IR (Moore). The one exception is `pc_src` in BRANCH, which equals `!eq` combinationally.
- **IDLE:** all outputs 0. Go to FETCH next cycle.
- **FETCH:** `imem_req`=1. When `imem_ready`=1, load IR from `imem_rdata` and go to DECODE. Otherwise stay in FETCH with `imem_req` held high.
- **DECODE:** classify IR.
  - opcode 7'd19 with funct3 000 (addi), or opcode 7'd3 with funct3 010 (lw): go to EXECUTE.
  - opcode 7'd99 with funct3 001 (bne): go to BRANCH.
  - anything else: go to TRAP.
- **EXECUTE:** `alu_ctrl`=ADD, `alu_src`=1, `imm_sel`=0. addi goes to WB; lw goes to MEM.
- **MEM:** `dmem_req`=1, with ALU controls held as in EXECUTE. When `dmem_ready`=1, go to WB; otherwise stay.
- **WB:** `reg_write`=1, `pc_en`=1, `pc_src`=0, ALU controls held. Go to FETCH.
- **BRANCH:** `alu_ctrl`=SUB, `alu_src`=0, `imm_sel`=1, `pc_en`=1, `pc_src`=`!eq`. Go to FETCH.
- **TRAP:** `trap`=1, all other outputs 0. Leaves only on `rst`.
- Outputs not listed for a state are 0.
- `imem_ready` is ignored outside FETCH; `dmem_ready` is ignored outside MEM.

## Timing
- Reset: state IDLE, IR = 32'h00000013 (canonical NOP), all outputs 0, `trap` 0.
- `rst` wins over every transition, including mid-MEM and mid-FETCH. Outstanding requests drop the cycle after `rst` is sampled high.
- First `imem_req` is asserted 1 cycle after `rst` deasserts.
- Latency from FETCH entry to `pc_en`, with ready high in the first request cycle:
  - addi: 4 cycles
  - lw: 5 cycles
  - bne: 3 cycles
- Each wait cycle on a ready signal adds one cycle.
- `pc_en` and `reg_write` are each high for exactly one cycle per retired instruction.
- IR changes only on the FETCH→DECODE edge.

## Configuration
- `INSTRET_EN` defined: adds output `instret` [31:0].
  - Resets to 0.
  - Increments on every cycle with `pc_en`=1.
  - Wraps 32'hFFFFFFFF→0.
  - Does not increment in TRAP.
- `INSTRET_EN` undefined: no `instret` port and no counter logic.

## Structure
- Package `rv_ctrl_pkg` holds:
  - the state enum;
  - opcode constants (OP_LOAD=7'd3, OP_IMM=7'd19, OP_BRANCH=7'd99);
  - funct3 constants;
  - ALU op constants (ALU_ADD, ALU_SUB);
  - `imm_sel` encodings.
- One sub-module, `rv_instr_classify`: combinational, IR → {is_addi, is_lw, is_bne, illegal}. It is used in DECODE and for the EXECUTE branch decision.

## Test plan
- Reset held 3 cycles, then released → all outputs 0 during reset; `imem_req`=1 on the 2nd cycle after release.
- Fetch `addi x1,x0,5` (32'h00500093) with `imem_ready` immediate → EXECUTE `alu_src`=1 `alu_ctrl`=000; WB `reg_write`=1 `pc_en`=1 `pc_src`=0, 4 cycles after FETCH entry.
- Fetch `lw x2,0(x1)` (32'h0000A103) with `dmem_ready` delayed 2 cycles → `dmem_req` held 3 cycles; `pc_en` 7 cycles after FETCH entry.
- Fetch `bne x1,x2,-4` (32'hFE209EE3):
  - with `eq`=0 → `pc_en`=1, `pc_src`=1, `imm_sel`=1, `reg_write`=0 in BRANCH;
  - with `eq`=1 → `pc_src`=0.
- Fetch 32'h00000033 (R-type) → `trap`=1 from the cycle after DECODE; no `pc_en`/`reg_write`; stays in TRAP until `rst`.
- Assert `rst` during MEM wait → `dmem_req` 0 next cycle; state returns to IDLE; `instret` (with `INSTRET_EN`) returns to 0.
